cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have miss_detected, input, 1, cache lookup missed; sampled only in IDLE.
REQ-004 SHALL have miss_address, input, 16, byte address of missing access; latched with miss_detected.
REQ-005 SHALL have memory_data_valid, input, 1, main memory returning one word this cycle.
REQ-006 SHALL have memory_data, input, 16, returned word; qualified by memory_data_valid.
REQ-007 SHALL have fsm_busy, output, 1, fill in progress; stalls the CPU pipeline.
REQ-008 SHALL have memory_read_en, output, 1, read request to main memory this cycle.
REQ-009 SHALL have memory_address, output, 16, word-aligned address of current request.
REQ-010 SHALL have write_data_array, output, 1, write cache_data_out into data array this cycle.
REQ-011 SHALL have word_offset, output, 3, index of word within block being written.
REQ-012 SHALL have cache_data_out, output, 16, word to write; equals memory_data.
REQ-013 SHALL have write_tag_array, output, 1, write tag/valid for latched block this cycle.

Function
REQ-014 SHALL implement two states: IDLE, FETCH; block = 8 words x 2 bytes = 16 bytes.
REQ-015 SHALL, in IDLE with miss_detected=1 at edge T, latch base = {miss_address[15:4],4'b0000} and enter FETCH at T+1.
REQ-016 SHALL drive fsm_busy=1 exactly while state==FETCH (registered state decode, no combinational path from miss_detected).
REQ-017 SHALL issue request i (i=0..7) on cycle T+1+i: memory_read_en=1, memory_address=base+2*i; memory_read_en=0 after 8 issues.
REQ-018 SHALL count returns: each FETCH cycle with memory_data_valid=1 asserts write_data_array=1, word_offset=return count, cache_data_out=memory_data, then increments count.
REQ-019 SHALL assert write_tag_array=1 in the same cycle as the 8th write_data_array, and enter IDLE on the next edge.
REQ-020 SHALL, with 4-cycle memory latency, return word i at T+5+i, tag write at T+12, fsm_busy=0 at T+13.
REQ-021 SHALL ignore miss_detected and miss_address while in FETCH; base held constant for whole fill.
REQ-022 SHALL ignore memory_data_valid in IDLE (no array writes, counters unchanged).
REQ-023 SHALL re-sample miss_detected in the first IDLE cycle after a fill; if high, start a new fill (back-to-back allowed).
REQ-024 SHALL keep issue and return counters independent; issue counter saturates after 8 requests, return counter wraps 7->0 only on leaving FETCH.
REQ-025 SHALL hold write_data_array, write_tag_array, memory_read_en at 0 whenever not explicitly asserted above.
REQ-026 SHALL handle miss_address with nonzero low 4 bits by aligning to block base (e.g. 0x123A -> 0x1230).

Reset
REQ-027 SHALL, on rst=1 at any edge including mid-fill, enter IDLE, clear both counters and base, abort fill without tag write.
REQ-028 SHALL drive after reset: fsm_busy=0, memory_read_en=0, memory_address=0, write_data_array=0, write_tag_array=0, word_offset=0, cache_data_out=memory_data.

Structure
REQ-029 SHALL take state encoding, BLOCK_WORDS=8, WORD_BYTES=2 from shared package cache_pkg (also used by the I- and D-cache).
REQ-030 SHALL use one sub-module, word_counter (3-bit counter with enable, sync clear, done flag), instantiated twice (issue, return).
REQ-031 SHALL be instantiated once per cache (I and D); arbitration between them is outside this block.

Verification
REQ-032 Basic fill: miss at 0x1230, 4-cycle memory -> requests 0x1230..0x123E on T+1..T+8, writes offsets 0..7 T+5..T+12, tag at T+12, busy low T+13.
REQ-033 Unaligned: miss_address=0x00FF -> first memory_address=0x00F0, last 0x00FE.
REQ-034 Back-to-back: miss held high through T+13 with new address 0x4000 -> new fill starts, memory_address=0x4000 at T+14.
REQ-035 Reset mid-fill: rst at T+7 -> next cycle fsm_busy=0, no write_tag_array, later valids ignored until next miss.
REQ-036 Spurious valid: memory_data_valid=1 in IDLE with data 0xBEEF -> write_data_array stays 0, next fill writes offset 0 first.
REQ-037 Miss during fill: toggle miss_detected with address 0x8000 at T+3 -> base stays 0x1230, single tag write at T+12.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: block geometry and fill FSM state encoding shared by the I- and D-cache.
package cache_pkg;
   localparam int BLOCK_WORDS = 8;
   localparam int WORD_BYTES = 2;
   localparam int OFFSET_BITS = $clog2(BLOCK_WORDS * WORD_BYTES);
   typedef enum logic {IDLE, FETCH} fill_state_t;
   function automatic logic [15:0] block_base(input logic [15:0] a);
      return {a[15:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   endfunction
endpackage

// File: rtl/cache_fill_fsm_word_counter.sv
// word_counter: counts up to the last word of a block, then holds and raises done until cleared.
module word_counter
   import cache_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   output logic [2:0] count,
   output logic       done
);
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= 3'd0;
         done <= 1'b0;
      end else if (en && !done) begin
         if (count == 3'(BLOCK_WORDS - 1)) done <= 1'b1;
         else count <= count + 3'd1;
      end
   end
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches one 8-word block from main memory on a miss and streams it into the arrays.
module cache_fill_fsm
   import cache_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   input  logic        memory_data_valid,
   input  logic [15:0] memory_data,
   output logic        fsm_busy,
   output logic        memory_read_en,
   output logic [15:0] memory_address,
   output logic        write_data_array,
   output logic [2:0]  word_offset,
   output logic [15:0] cache_data_out,
   output logic        write_tag_array
);
   fill_state_t state;
   logic [15:0] base;
   logic [2:0] issue_cnt, ret_cnt;
   logic issue_done, ret_done, fill_end;
   assign fsm_busy = state == FETCH;
   assign memory_read_en = fsm_busy && !issue_done;
   assign memory_address = base + 16'(issue_cnt) * 16'(WORD_BYTES);
   assign write_data_array = fsm_busy && memory_data_valid;
   assign word_offset = ret_cnt;
   assign cache_data_out = memory_data;
   // the last return of the block commits the tag and closes the fill
   assign fill_end = write_data_array && ret_cnt == 3'(BLOCK_WORDS - 1) && !ret_done;
   assign write_tag_array = fill_end;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         base <= 16'd0;
      end else if (state == IDLE && miss_detected) begin
         state <= FETCH;
         base <= block_base(miss_address);
      end else if (fill_end) begin
         state <= IDLE;
      end
   end
   word_counter u_issue (
      .clk(clk), .rst(rst), .clr(fill_end), .en(memory_read_en),
      .count(issue_cnt), .done(issue_done)
   );
   word_counter u_return (
      .clk(clk), .rst(rst), .clr(fill_end), .en(write_data_array),
      .count(ret_cnt), .done(ret_done)
   );
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed fills; expected requests/writes/tag writes are queued and checked by a monitor.
module tb_cache_fill_fsm;
   logic clk = 1'b0, rst = 1'b1;
   logic miss_detected = 1'b0, memory_data_valid = 1'b0;
   logic [15:0] miss_address = 16'd0, memory_data = 16'd0;
   logic fsm_busy, memory_read_en, write_data_array, write_tag_array;
   logic [15:0] memory_address, cache_data_out;
   logic [2:0] word_offset;
   int total = 0, bad = 0, cyc = 0;
   bit mon_on = 1'b0;
   typedef struct {int cyc; logic [15:0] val; logic [2:0] off;} ev_t;
   ev_t req_q[$], wr_q[$], tag_q[$];
   ev_t me;

   cache_fill_fsm dut (
      .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
      .memory_data_valid(memory_data_valid), .memory_data(memory_data), .fsm_busy(fsm_busy),
      .memory_read_en(memory_read_en), .memory_address(memory_address),
      .write_data_array(write_data_array), .word_offset(word_offset),
      .cache_data_out(cache_data_out), .write_tag_array(write_tag_array)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) if (mon_on) begin
      if (memory_read_en) begin
         chk("req_pending", 16'(req_q.size() > 0), 16'd1);
         if (req_q.size() > 0) begin
            me = req_q.pop_front();
            chk("req_addr", memory_address, me.val);
            chk("req_cycle", 16'(cyc), 16'(me.cyc));
         end
      end
      if (write_data_array) begin
         chk("wr_pending", 16'(wr_q.size() > 0), 16'd1);
         if (wr_q.size() > 0) begin
            me = wr_q.pop_front();
            chk("wr_data", cache_data_out, me.val);
            chk("wr_offset", 16'(word_offset), 16'(me.off));
            chk("wr_cycle", 16'(cyc), 16'(me.cyc));
         end
      end
      if (write_tag_array) begin
         chk("tag_pending", 16'(tag_q.size() > 0), 16'd1);
         chk("tag_with_write", 16'(write_data_array), 16'd1);
         if (tag_q.size() > 0) begin
            me = tag_q.pop_front();
            chk("tag_offset", 16'(word_offset), 16'(me.off));
            chk("tag_cycle", 16'(cyc), 16'(me.cyc));
         end
      end
   end

   // Miss raised in the current cycle t; requests at t+1..t+8, returns at t+5..t+12, idle at t+13.
   task automatic fill(input logic [15:0] a, input logic [15:0] b, input logic [15:0] seed,
                       input bit intr, input bit chain, input logic [15:0] nxt);
      int t;
      t = cyc;
      for (int i = 0; i < 8; i++) begin
         req_q.push_back('{t + 1 + i, 16'(b + 16'(2 * i)), 3'd0});
         wr_q.push_back('{t + 5 + i, 16'(seed + 16'(i)), 3'(i)});
      end
      tag_q.push_back('{t + 12, 16'd0, 3'd7});
      miss_detected = 1'b1;
      miss_address = a;
      for (int k = 1; k <= 12; k++) begin
         step();
         chk("busy_fill", 16'(fsm_busy), 16'd1);
         miss_detected = 1'b0;
         if (intr && k == 3) begin
            miss_detected = 1'b1;
            miss_address = 16'h8000;
         end
         memory_data_valid = k >= 5;
         memory_data = 16'(seed + 16'(k - 5));
         if (chain && k == 12) begin
            miss_detected = 1'b1;
            miss_address = nxt;
         end
      end
      step();
      memory_data_valid = 1'b0;
      chk("busy_end", 16'(fsm_busy), 16'd0);
   endtask

   initial begin
      int t;
      memory_data = 16'h5A5A;
      repeat (3) step();
      chk("rst_busy", 16'(fsm_busy), 16'd0);
      chk("rst_read_en", 16'(memory_read_en), 16'd0);
      chk("rst_addr", memory_address, 16'd0);
      chk("rst_wda", 16'(write_data_array), 16'd0);
      chk("rst_wta", 16'(write_tag_array), 16'd0);
      chk("rst_offset", 16'(word_offset), 16'd0);
      chk("rst_data_out", cache_data_out, 16'h5A5A);
      rst = 1'b0;
      mon_on = 1'b1;
      memory_data_valid = 1'b1;
      memory_data = 16'hBEEF;
      step();
      step();
      chk("spurious_wda", 16'(write_data_array), 16'd0);
      chk("spurious_busy", 16'(fsm_busy), 16'd0);
      memory_data_valid = 1'b0;
      step();
      fill(16'h1230, 16'h1230, 16'hA000, 1'b0, 1'b1, 16'h4000);
      fill(16'h4000, 16'h4000, 16'hB100, 1'b0, 1'b0, 16'h0000);
      step();
      fill(16'h00FF, 16'h00F0, 16'hC200, 1'b0, 1'b0, 16'h0000);
      step();
      fill(16'h1230, 16'h1230, 16'hD300, 1'b1, 1'b0, 16'h0000);
      step();
      t = cyc;
      for (int i = 0; i < 7; i++) req_q.push_back('{t + 1 + i, 16'(16'h2000 + 16'(2 * i)), 3'd0});
      for (int i = 0; i < 3; i++) wr_q.push_back('{t + 5 + i, 16'(16'h3000 + 16'(i)), 3'(i)});
      miss_detected = 1'b1;
      miss_address = 16'h2004;
      for (int k = 1; k <= 7; k++) begin
         step();
         miss_detected = 1'b0;
         memory_data_valid = k >= 5;
         memory_data = 16'(16'h3000 + 16'(k - 5));
         if (k == 7) rst = 1'b1;
      end
      step();
      rst = 1'b0;
      chk("abort_busy", 16'(fsm_busy), 16'd0);
      chk("abort_read_en", 16'(memory_read_en), 16'd0);
      chk("abort_addr", memory_address, 16'd0);
      for (int k = 0; k < 4; k++) begin
         memory_data = 16'(16'h3100 + 16'(k));
         step();
         chk("abort_late_wda", 16'(write_data_array), 16'd0);
      end
      memory_data_valid = 1'b0;
      fill(16'h004C, 16'h0040, 16'hE400, 1'b0, 1'b0, 16'h0000);
      repeat (4) step();
      chk("req_left", 16'(req_q.size()), 16'd0);
      chk("wr_left", 16'(wr_q.size()), 16'd0);
      chk("tag_left", 16'(tag_q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
